// File: rtl/rate_limiter_pkg.sv
// Shared types, default sizing and the per-channel next-value rule for the
// multi-channel slew-rate limiter.
package rate_limiter_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_STEP_W = 4;
   localparam int unsigned DEF_NUM_CH = 4;
   // Widest DATA_W the shared next-value function can handle.
   localparam int unsigned MAX_W      = 32;

   typedef enum logic {
      MODE_LINEAR = 1'b0,
      MODE_WRAP   = 1'b1
   } mode_e;

   // Operands arrive zero-extended to MAX_W; data_w masks the modular
   // arithmetic back down to the channel width.
   function automatic logic [MAX_W-1:0] next_value(
      input logic [MAX_W-1:0] out,
      input logic [MAX_W-1:0] target,
      input logic [MAX_W-1:0] step_up,
      input logic [MAX_W-1:0] step_dn,
      input mode_e            mode,
      input int unsigned      data_w
   );
      logic [MAX_W:0] mask, o, t, su, sd, du, dd, res;
      mask = ({{MAX_W{1'b0}}, 1'b1} << data_w) - {{MAX_W{1'b0}}, 1'b1};
      o    = {1'b0, out};
      t    = {1'b0, target};
      su   = {1'b0, step_up};
      sd   = {1'b0, step_dn};
      du   = (t - o) & mask;
      dd   = (o - t) & mask;
      res  = o;
      if (mode == MODE_WRAP) begin
         // Ties go upward; du==0 also lands here and leaves o unchanged.
         if (du <= dd) res = (o + ((su < du) ? su : du)) & mask;
         else          res = (o - ((sd < dd) ? sd : dd)) & mask;
      end else if (t > o) begin
         res = o + ((su < (t - o)) ? su : (t - o));
      end else if (t < o) begin
         res = o - ((sd < (o - t)) ? sd : (o - t));
      end
      return res[MAX_W-1:0];
   endfunction

endpackage

// File: rtl/rl_channel.sv
// One limiter channel: configuration registers, registered output and the
// settled flag.
module rl_channel
   import rate_limiter_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned STEP_W = DEF_STEP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [DATA_W-1:0] target,
   input  logic [STEP_W-1:0] step_up,
   input  logic [STEP_W-1:0] step_dn,
   input  logic              wrap,
   output logic [DATA_W-1:0] value,
   output logic              settled
);

   logic [DATA_W-1:0] target_q;
   logic [STEP_W-1:0] up_q;
   logic [STEP_W-1:0] dn_q;
   mode_e             mode_q;
   logic [DATA_W-1:0] nxt;

   always_comb begin
      nxt = DATA_W'(next_value(MAX_W'(value), MAX_W'(target_q), MAX_W'(up_q),
                               MAX_W'(dn_q), mode_q, DATA_W));
   end

   // Motion uses the pre-edge registers, so a write steers from the next edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value    <= '0;
         target_q <= '0;
         up_q     <= '0;
         dn_q     <= '0;
         mode_q   <= MODE_LINEAR;
      end else begin
         value <= nxt;
         if (we) begin
            target_q <= target;
            up_q     <= step_up;
            dn_q     <= step_dn;
            mode_q   <= wrap ? MODE_WRAP : MODE_LINEAR;
         end
      end
   end

   assign settled = (value == target_q);

endmodule

// File: rtl/rate_limiter_mc.sv
// Multi-channel slew-rate limiter: write decode, NUM_CH channel instances and
// the busy reduction.
module rate_limiter_mc
   import rate_limiter_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned STEP_W = DEF_STEP_W,
   parameter int unsigned NUM_CH = DEF_NUM_CH,
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_we,
   input  logic [CH_W-1:0]          cfg_ch,
   input  logic [DATA_W-1:0]        cfg_target,
   input  logic [STEP_W-1:0]        cfg_step_up,
   input  logic [STEP_W-1:0]        cfg_step_dn,
   input  logic                     cfg_wrap,
   output logic [NUM_CH*DATA_W-1:0] d_out,
   output logic [NUM_CH-1:0]        settled,
   output logic                     busy
);

   // Channel indices at or above NUM_CH match no instance, so such writes drop.
   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      logic ch_we;
      assign ch_we = cfg_we && (cfg_ch == CH_W'(n));

      rl_channel #(
         .DATA_W (DATA_W),
         .STEP_W (STEP_W)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .we      (ch_we),
         .target  (cfg_target),
         .step_up (cfg_step_up),
         .step_dn (cfg_step_dn),
         .wrap    (cfg_wrap),
         .value   (d_out[n*DATA_W +: DATA_W]),
         .settled (settled[n])
      );
   end

   assign busy = |(~settled);

endmodule

// File: tb/tb_rate_limiter_mc.sv
// Bench for rate_limiter_mc: directed scenarios plus randomized traffic
// checked against an arithmetic reference of the slew rules.
module tb_rate_limiter_mc;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [1:0]  cfg_ch;
   logic [7:0]  cfg_target;
   logic [3:0]  cfg_step_up;
   logic [3:0]  cfg_step_dn;
   logic        cfg_wrap;
   logic [31:0] d_out;
   logic [3:0]  settled;
   logic        busy;

   logic        cfg_we5;
   logic [2:0]  cfg_ch5;
   logic [39:0] d_out5;
   logic [4:0]  settled5;
   logic        busy5;

   int tests = 0;
   int fails = 0;

   int mo[4], mt[4], mu[4], md[4], mw[4];

   rate_limiter_mc #(.DATA_W(8), .STEP_W(4), .NUM_CH(4)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_target(cfg_target), .cfg_step_up(cfg_step_up),
      .cfg_step_dn(cfg_step_dn), .cfg_wrap(cfg_wrap),
      .d_out(d_out), .settled(settled), .busy(busy)
   );

   rate_limiter_mc #(.DATA_W(8), .STEP_W(4), .NUM_CH(5)) dut5 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we5), .cfg_ch(cfg_ch5),
      .cfg_target(cfg_target), .cfg_step_up(cfg_step_up),
      .cfg_step_dn(cfg_step_dn), .cfg_wrap(cfg_wrap),
      .d_out(d_out5), .settled(settled5), .busy(busy5)
   );

   always #5 clk = ~clk;

   function automatic int mnext(int o, int t, int u, int d, int w);
      int du, dd;
      if (w != 0) begin
         du = (t - o + 256) % 256;
         dd = (o - t + 256) % 256;
         if (du <= dd) return (o + ((u < du) ? u : du)) % 256;
         return (o - ((d < dd) ? d : dd) + 256) % 256;
      end
      if (t > o) return o + ((u < t - o) ? u : t - o);
      if (t < o) return o - ((d < o - t) ? d : o - t);
      return o;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 4; c++) begin
         mo[c] = 0; mt[c] = 0; mu[c] = 0; md[c] = 0; mw[c] = 0;
      end
   endtask

   task automatic model_edge(input bit we, input int ch, input int t,
                             input int u, input int d, input bit w);
      int nx[4];
      for (int c = 0; c < 4; c++) nx[c] = mnext(mo[c], mt[c], mu[c], md[c], mw[c]);
      for (int c = 0; c < 4; c++) mo[c] = nx[c];
      if (we && ch < 4) begin
         mt[ch] = t; mu[ch] = u; md[ch] = d; mw[ch] = int'(w);
      end
   endtask

   function automatic logic [31:0] exp_out();
      logic [31:0] v;
      for (int c = 0; c < 4; c++) v[c*8 +: 8] = 8'(mo[c]);
      return v;
   endfunction

   function automatic logic [3:0] exp_settled();
      logic [3:0] s;
      for (int c = 0; c < 4; c++) s[c] = (mo[c] == mt[c]);
      return s;
   endfunction

   task automatic tick(input bit we, input int ch, input int t,
                       input int u, input int d, input bit w);
      @(negedge clk);
      cfg_we      = we;
      cfg_ch      = ch[1:0];
      cfg_target  = t[7:0];
      cfg_step_up = u[3:0];
      cfg_step_dn = d[3:0];
      cfg_wrap    = w;
      @(posedge clk);
      model_edge(we, ch, t, u, d, w);
      #1;
      cfg_we = 1'b0;
   endtask

   task automatic idle();
      tick(1'b0, 0, 0, 0, 0, 1'b0);
   endtask

   task automatic settle(input int ch, input int lim);
      int n = 0;
      while (mo[ch] != mt[ch] && n < lim) begin
         idle();
         n++;
      end
      tests++;
      if (d_out[ch*8 +: 8] !== 8'(mt[ch])) begin
         fails++;
         $display("FAIL settle ch%0d: got %0d want %0d within %0d cycles",
                  ch, d_out[ch*8 +: 8], mt[ch], lim);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      tests++;
      if (d_out !== 32'h0 || settled !== 4'hF || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: d_out=%h settled=%b busy=%b want 0/1111/0",
                  d_out, settled, busy);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_linear_up();
      int ex[5] = '{7, 14, 21, 28, 30};
      tick(1'b1, 0, 30, 7, 0, 1'b0);
      tests++;
      if (d_out[7:0] !== 8'd0 || settled[0] !== 1'b0) begin
         fails++;
         $display("FAIL lin_up_latency: got %0d settled=%b want 0/0", d_out[7:0], settled[0]);
      end
      for (int i = 0; i < 5; i++) begin
         idle();
         tests++;
         if (d_out[7:0] !== 8'(ex[i]) || settled[0] !== (i == 4)) begin
            fails++;
            $display("FAIL lin_up step %0d: got %0d settled=%b want %0d settled=%b",
                     i, d_out[7:0], settled[0], ex[i], (i == 4));
         end
      end
   endtask

   task automatic test_linear_down();
      int e = 200;
      tick(1'b1, 1, 200, 15, 15, 1'b0);
      settle(1, 40);
      tick(1'b1, 1, 10, 0, 15, 1'b0);
      for (int i = 0; i < 16; i++) begin
         idle();
         e = (e - 15 < 10) ? 10 : e - 15;
         tests++;
         if (d_out[15:8] !== 8'(e) || d_out[15:8] < 8'd10) begin
            fails++;
            $display("FAIL lin_down step %0d: got %0d want %0d", i, d_out[15:8], e);
         end
      end
   endtask

   task automatic test_wrap();
      int ex[4] = '{253, 0, 3, 4};
      int e;
      tick(1'b1, 2, 250, 15, 15, 1'b0);
      settle(2, 40);
      tick(1'b1, 2, 4, 3, 0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         idle();
         tests++;
         if (d_out[23:16] !== 8'(ex[i])) begin
            fails++;
            $display("FAIL wrap step %0d: got %0d want %0d", i, d_out[23:16], ex[i]);
         end
      end
      tick(1'b1, 2, 250, 15, 15, 1'b0);
      settle(2, 40);
      tick(1'b1, 2, 4, 3, 15, 1'b0);
      e = 250;
      for (int i = 0; i < 18; i++) begin
         idle();
         e = (e - 15 < 4) ? 4 : e - 15;
         tests++;
         if (d_out[23:16] !== 8'(e)) begin
            fails++;
            $display("FAIL wrap_off_linear step %0d: got %0d want %0d", i, d_out[23:16], e);
         end
      end
   endtask

   task automatic test_hold();
      tick(1'b1, 3, 100, 0, 0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         idle();
         tests++;
         if (d_out[31:24] !== 8'd0 || settled[3] !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL hold cycle %0d: out=%0d settled=%b busy=%b want 0/0/1",
                     i, d_out[31:24], settled[3], busy);
         end
      end
   endtask

   task automatic test_ignore();
      for (int ch = 5; ch < 8; ch++) begin
         @(negedge clk);
         cfg_we5 = 1'b1; cfg_ch5 = 3'(ch);
         cfg_target = 8'd200; cfg_step_up = 4'd15; cfg_step_dn = 4'd15; cfg_wrap = 1'b1;
         @(posedge clk);
         model_edge(1'b0, 0, 0, 0, 0, 1'b0);
         #1 cfg_we5 = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
         idle();
         tests++;
         if (d_out5 !== 40'h0 || settled5 !== 5'h1F || busy5 !== 1'b0) begin
            fails++;
            $display("FAIL ignore_range cycle %0d: d_out5=%h settled5=%b busy5=%b",
                     i, d_out5, settled5, busy5);
         end
      end
      @(negedge clk);
      cfg_we5 = 1'b1; cfg_ch5 = 3'd4;
      cfg_target = 8'd9; cfg_step_up = 4'd15; cfg_step_dn = 4'd0; cfg_wrap = 1'b0;
      @(posedge clk);
      model_edge(1'b0, 0, 0, 0, 0, 1'b0);
      #1 cfg_we5 = 1'b0;
      idle();
      tests++;
      if (d_out5 !== {8'd9, 32'h0} || settled5 !== 5'h1F) begin
         fails++;
         $display("FAIL last_channel_write: d_out5=%h settled5=%b want %h/11111",
                  d_out5, settled5, {8'd9, 32'h0});
      end
   endtask

   task automatic test_parallel();
      for (int c = 0; c < 4; c++)
         tick(1'b1, c, $urandom_range(255), $urandom_range(15, 1),
              $urandom_range(15, 1), 1'($urandom_range(1)));
      for (int i = 0; i < 16; i++) begin
         if (i == 5)
            tick(1'b1, 3, $urandom_range(255), $urandom_range(15, 1),
                 $urandom_range(15, 1), 1'($urandom_range(1)));
         else
            idle();
         tests++;
         if (d_out !== exp_out() || settled !== exp_settled()) begin
            fails++;
            $display("FAIL parallel cycle %0d: d_out=%h settled=%b want %h/%b",
                     i, d_out, settled, exp_out(), exp_settled());
         end
      end
   endtask

   task automatic test_reset_mid();
      tick(1'b1, 0, 255, 1, 1, 1'b0);
      tick(1'b1, 1, 128, 3, 3, 1'b1);
      repeat (3) idle();
      @(posedge clk);
      model_edge(1'b0, 0, 0, 0, 0, 1'b0);
      #3 rst = 1'b1;
      #1;
      model_reset();
      tests++;
      if (d_out !== 32'h0 || settled !== 4'hF || busy !== 1'b0) begin
         fails++;
         $display("FAIL async_reset: d_out=%h settled=%b busy=%b want 0/1111/0",
                  d_out, settled, busy);
      end
      // Release rst and write on the very first edge afterwards.
      @(negedge clk);
      rst = 1'b0;
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_target = 8'd5;
      cfg_step_up = 4'd15; cfg_step_dn = 4'd0; cfg_wrap = 1'b0;
      @(posedge clk);
      model_edge(1'b1, 0, 5, 15, 0, 1'b0);
      #1 cfg_we = 1'b0;
      idle();
      tests++;
      if (d_out !== 32'h0000_0005 || settled !== 4'hF) begin
         fails++;
         $display("FAIL first_edge_write: d_out=%h settled=%b want 00000005/1111",
                  d_out, settled);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         tick(1'($urandom_range(1)), $urandom_range(3), $urandom_range(255),
              $urandom_range(15), $urandom_range(15), 1'($urandom_range(1)));
         tests++;
         if (d_out !== exp_out() || settled !== exp_settled() || busy !== ~&exp_settled()) begin
            fails++;
            $display("FAIL random cycle %0d: d_out=%h settled=%b busy=%b want %h/%b/%b",
                     i, d_out, settled, busy, exp_out(), exp_settled(), ~&exp_settled());
         end
      end
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_target = '0;
      cfg_step_up = '0; cfg_step_dn = '0; cfg_wrap = 1'b0;
      cfg_we5 = 1'b0; cfg_ch5 = '0;
      model_reset();
      test_reset();
      test_linear_up();
      test_linear_down();
      test_wrap();
      test_hold();
      test_ignore();
      test_parallel();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rate_limiter_mc.md
RATE_LIMITER_MC -- requirements
Module: rate_limiter_mc

Interface
REQ-001 Parameter DATA_W, default 8, width of each target and output value.
REQ-002 Parameter STEP_W, default 4, width of each step size.
REQ-003 Parameter NUM_CH, default 4, number of independent channels (at least 1); CH_W = max(1, clog2(NUM_CH)).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cfg_we  input  1  configuration write strobe, one write per cycle.
REQ-007 cfg_ch  input  CH_W  target channel of the write.
REQ-008 cfg_target  input  DATA_W  new target value.
REQ-009 cfg_step_up  input  STEP_W  maximum upward change per cycle.
REQ-010 cfg_step_dn  input  STEP_W  maximum downward change per cycle.
REQ-011 cfg_wrap  input  1  channel mode: 0 = saturating linear, 1 = modular shortest-path.
REQ-012 d_out  output  NUM_CH*DATA_W  packed registered outputs; channel n occupies bits [n*DATA_W +: DATA_W].
REQ-013 settled  output  NUM_CH  per-channel flag, high when output equals target.
REQ-014 busy  output  1  OR of the inverse of all settled bits.

Function
REQ-015 A write with cfg_we=1 and cfg_ch<NUM_CH shall load target, step_up, step_dn and wrap into that channel's registers on the edge.
REQ-016 Writes with cfg_ch>=NUM_CH shall be ignored with no state change.
REQ-017 Each channel shall update every cycle in parallel, using its register values from before the edge; a write therefore affects motion from the following edge (1-cycle latency).
REQ-018 Linear mode with target>out: out becomes out + min(step_up, target-out).
REQ-019 Linear mode with target<out: out becomes out - min(step_dn, out-target).
REQ-020 Linear mode: the output shall never overshoot the target and never wrap past 0 or 2^DATA_W-1.
REQ-021 Wrap mode: up-distance du = (target-out) mod 2^DATA_W and down-distance dd = (out-target) mod 2^DATA_W.
REQ-022 Wrap mode: move up by min(step_up, du) if du<=dd, else down by min(step_dn, dd), with modulo-2^DATA_W arithmetic.
REQ-023 Wrap mode tie break: if du==dd, the channel moves up.
REQ-024 A step size of 0 in the required direction shall hold the output indefinitely, with settled low if out!=target.
REQ-025 A mode change mid-slew takes effect on the next edge from the current output; no restart.
REQ-026 settled and busy shall be combinational from registered state only; they are not a function of cfg_* inputs.
REQ-027 Intermediate arithmetic shall use DATA_W+1 bits; step values are zero-extended.

Reset
REQ-028 While rst is high, all d_out = 0, all targets = 0, all steps = 0, all wrap = 0, settled = all ones, and busy = 0, applied asynchronously.
REQ-029 Reset asserted mid-slew shall abort the slew immediately; after release, channels remain at 0 until rewritten.
REQ-030 A cfg_we on the first edge after reset deassertion shall be accepted.

Structure
REQ-031 Package rate_limiter_pkg holds: default DATA_W, STEP_W and NUM_CH constants; a typedef enum for mode (MODE_LINEAR, MODE_WRAP); and a function computing the next value from (out, target, step_up, step_dn, mode).
REQ-032 Sub-module rl_channel implements one channel (its registers plus next-value logic); the top generates NUM_CH instances plus write decode and busy reduction.

Verification (DATA_W=8, STEP_W=4, NUM_CH=4)
REQ-033 Reset: hold rst for 2 cycles -> d_out = 0, settled = 4'b1111, busy = 0; then pulse rst asynchronously mid-cycle -> outputs clear before the next edge.
REQ-034 Linear up: write ch0 target 30, up 7 -> d_out[0] reads 7, 14, 21, 28, 30 on successive edges after the write edge; settled[0] rises with 30.
REQ-035 Linear down, no undershoot: ch1 at 200, write target 10, dn 15 -> 185, 170, ..., 20, 10; never below 10.
REQ-036 Wrap mode: ch2 at 250, write target 4, up 3, wrap 1 -> 253, 0, 3, 4. Same case with wrap 0 and dn 15 -> decreases linearly to 4.
REQ-037 Hold and ignore: step 0 with target != out -> output constant and settled low. A write to cfg_ch=4 with NUM_CH=4 (requires CH_W>=3 in a dedicated build) -> no change.
REQ-038 Parallel and simultaneous: all four channels slewing concurrently while ch3 is rewritten mid-slew -> ch3 redirects on the next edge, other channels unaffected; rst mid-slew -> all outputs 0.
